uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares a single `uart_byte_tx` transmitter between `N_REQ` byte producers. It selects one requester, latches its byte, drives `Sent_en`/`Data_byte` into the transmitter, waits for `Tx_done`, then enforces a programmable idle gap before the next grant. It sits between the producer blocks and the `uart_byte_tx` instance. It replaces free-running counter-based `Sent_en` generation.

## Interface

Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `GAP_CYCLES`, 16: idle clocks inserted after each byte (0 allowed).
- `TIMEOUT_CYCLES`, 200000: max clocks in SEND before abort. Must exceed one 10-bit frame at the slowest baud; 9600 Bd at 50 MHz is about 52080.

Ports:
- `Clk` in 1: system clock.
- `Reset` in 1: synchronous, active-high reset.
- `Req` in N_REQ: per-requester request level. Hold high until `Grant` bit seen.
- `Req_data` in 8*N_REQ: byte of requester i on bits [8i+7:8i].
- `Grant` out N_REQ: one-hot, one-cycle pulse when requester's byte is latched.
- `Done` out N_REQ: one-hot, one-cycle pulse when requester's byte finished.
- `Err` out N_REQ: one-hot, one-cycle pulse on timeout abort.
- `Busy` out 1: high in SEND and GAP.
- `Sent_en` out 1: to transmitter `Sent_en`.
- `Data_byte` out 8: to transmitter `Data_byte`.
- `Tx_done` in 1: one-cycle done pulse from transmitter.

## Operation

- The block has three states: IDLE, SEND and GAP.
- **Round-robin pointer `ptr`** (index of last served requester):
  - Reset value is N_REQ-1, so requester 0 has first priority.
  - The search for a winner starts at ptr+1 and wraps modulo N_REQ.
- **IDLE**:
  - If `Req` is non-zero, pick winner w and latch `Data_byte` <= `Req_data[w]`.
  - Set `Sent_en` <= 1 and pulse `Grant[w]`.
  - Set cur <= w and go to SEND.
  - Otherwise remain in IDLE.
- **SEND**:
  - Hold `Sent_en`=1 and `Data_byte` stable.
  - On `Tx_done`=1: set `Sent_en` <= 0, pulse `Done[cur]` and set ptr <= cur.
  - Load the gap counter. Go to GAP, or go directly to IDLE if GAP_CYCLES=0.
- **GAP**:
  - Count down GAP_CYCLES clocks, then go to IDLE.
  - `Req` is ignored during GAP.
- **Ignored inputs:**
  - `Tx_done` is ignored in IDLE and GAP.
  - `Req` changes after grant do not affect the byte in flight.
- **Withdrawn requests:** a requester dropping `Req` before its grant is simply not selected. No error is raised.
- **Counter widths:** both counters are `$clog2(max+1)` bits. Counters saturate, never wrap.

## Timing

- **Reset values:**
  - `Grant`, `Done`, `Err`, `Busy`, `Sent_en` = 0; `Data_byte` = 8'h00.
  - State = IDLE; ptr = N_REQ-1; counters = 0.
- **Grant latency:** `Req` sampled high at edge t in IDLE gives `Grant`, `Sent_en`, `Data_byte` and `Busy` valid after edge t (1 cycle).
- **Completion:** `Tx_done` sampled at edge d gives `Sent_en`=0 and the `Done` pulse after edge d.
- **Next grant:** earliest at edge d+GAP_CYCLES+1. `Busy` falls together with the return to IDLE.
- **Reset mid-operation:** on the next edge all outputs return to reset values and no `Done` is issued. The transmitter is reset by its own reset path.
- **Simultaneous requests:** exactly one grant per arbitration. Losers keep `Req` high and win in later rounds in rotation order.

## Configuration

- Macro `UART_TX_ARB_TIMEOUT_EN` enables the SEND watchdog.
- **Defined:**
  - A counter clears on entry to SEND and increments each SEND cycle.
  - If it reaches TIMEOUT_CYCLES with no `Tx_done`: `Sent_en` <= 0, pulse `Err[cur]` (no `Done`), set ptr <= cur, enter GAP.
  - If `Tx_done` and timeout coincide, `Tx_done` wins.
- **Undefined:**
  - No watchdog logic is built; `Err` is tied 0.
  - SEND waits indefinitely for `Tx_done`.

## Test plan

- **Single request:** N_REQ=4, GAP_CYCLES=16, requester 2 raises `Req` with 8'hA5.
  - `Grant`=4'b0100 one cycle later; `Sent_en`=1 and `Data_byte`=8'hA5 until `Tx_done`.
  - `Done`=4'b0100 one cycle after `Tx_done`; next grant no earlier than 17 cycles after `Tx_done`.
- **Full contention:** all four `Req` held with distinct bytes.
  - Grants in order 0,1,2,3,0.
  - Each `Data_byte` matches its requester; exactly one `Grant` bit per grant.
- **Zero gap:** GAP_CYCLES=0 with requesters 0 and 1 pending.
  - Grant for requester 1 occurs two cycles after `Tx_done` of requester 0.
- **Stray `Tx_done`:** pulse `Tx_done` while in IDLE and while in GAP.
  - No `Done` pulse, no state change.
- **Watchdog:** with `UART_TX_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=100, suppress `Tx_done`.
  - `Err[cur]` pulses and `Sent_en` drops after exactly 100 SEND cycles; the next requester is served afterward.
  - Without the macro, `Sent_en` stays high indefinitely.
- **Reset mid-send:** assert `Reset` mid-SEND.
  - Next cycle all outputs are 0 and `Data_byte`=8'h00.
  - After release, requester 0 wins the first contention.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter/sequencer sharing one uart_byte_tx between N_REQ
// byte producers: grant, latch byte, hold Sent_en until Tx_done, then
// insert GAP_CYCLES idle clocks before the next grant.
// Optional SEND watchdog built when UART_TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [N_REQ-1:0]     Req,
    input  logic [8*N_REQ-1:0]   Req_data,
    output logic [N_REQ-1:0]     Grant,
    output logic [N_REQ-1:0]     Done,
    output logic [N_REQ-1:0]     Err,
    output logic                 Busy,
    output logic                 Sent_en,
    output logic [7:0]           Data_byte,
    input  logic                 Tx_done
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    // With no gap configured, a finished byte returns straight to IDLE.
    localparam logic [1:0]       S_AFTER  = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    logic [1:0]       state;
    logic [PTR_W-1:0] ptr;        // last served requester
    logic [PTR_W-1:0] cur;        // requester whose byte is in flight
    logic [GAP_W-1:0] gap_cnt;
    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [N_REQ-1:0] win_onehot;
    logic [N_REQ-1:0] cur_onehot;

    // Index of the k-th requester after base, wrapping modulo N_REQ.
    function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base,
                                                   input int step);
        int s;
        s = (int'(base) + step) % N_REQ;
        return PTR_W'(s);
    endfunction

    // Round-robin search: first active Req starting at ptr+1.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!win_found && Req[rr_index(ptr, k)]) begin
                win_found = 1'b1;
                win_idx   = rr_index(ptr, k);
            end
        end
    end

    assign win_onehot = N_REQ'(1) << win_idx;
    assign cur_onehot = N_REQ'(1) << cur;
    assign Busy       = (state != S_IDLE);

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = '1;
    logic [WD_W-1:0] wd_cnt;
`else
    // No watchdog: SEND waits for Tx_done indefinitely.
    assign Err = '0;
`endif

    // Main sequencer: IDLE -> SEND -> GAP -> IDLE, pulses cleared each cycle.
    always_ff @(posedge Clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (Reset) begin
            state     <= S_IDLE;
            ptr       <= PTR_W'(N_REQ - 1);
            cur       <= '0;
            gap_cnt   <= '0;
            Grant     <= '0;
            Done      <= '0;
            Sent_en   <= 1'b0;
            Data_byte <= 8'h00;
`ifdef UART_TX_ARB_TIMEOUT_EN
            Err       <= '0;
            wd_cnt    <= '0;
`endif
        end else begin
            Grant <= '0;
            Done  <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            Err   <= '0;
`endif
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        Data_byte <= Req_data[{win_idx, 3'b000} +: 8];
                        Sent_en   <= 1'b1;
                        Grant     <= win_onehot;
                        cur       <= win_idx;
                        state     <= S_SEND;
`ifdef UART_TX_ARB_TIMEOUT_EN
                        wd_cnt    <= '0;
`endif
                    end
                end
                S_SEND: begin
                    if (Tx_done) begin
                        Sent_en <= 1'b0;
                        Done    <= cur_onehot;
                        ptr     <= cur;
                        gap_cnt <= GAP_LOAD;
                        state   <= S_AFTER;
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    else if (wd_cnt == WD_LAST) begin
                        // Transmitter never answered: abort this byte.
                        Sent_en <= 1'b0;
                        Err     <= cur_onehot;
                        ptr     <= cur;
                        gap_cnt <= GAP_LOAD;
                        state   <= S_AFTER;
                    end else if (wd_cnt != WD_MAX) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                S_GAP: begin
                    // Last gap clock when the counter is at 1 (or already 0).
                    if (gap_cnt <= GAP_W'(1)) begin
                        gap_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
